// File: rtl/req_initiator_pkg.sv
// Shared types and constants for the request initiator.
package req_init_pkg;
    localparam int TIMEOUT_DEF   = 4;
    localparam int MAX_RETRY_DEF = 2;
    localparam int PEND_W        = 2;
    localparam int RETRY_W       = 2;
    localparam int WCNT_W        = 4;
    localparam int GCNT_W        = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_GAP
    } state_e;
endpackage

// File: rtl/req_initiator_if.sv
// Job/arbiter handshake bundle between the initiator and its environment.
interface req_initiator_if;
    import req_init_pkg::*;

    logic              start;
    logic              gnt;
    logic              req;
    logic              busy;
    logic              done;
    logic              abort;
    logic              overflow;
    logic              spurious;
    logic [GCNT_W-1:0] grant_cnt;

    modport master (
        input  start, gnt,
        output req, busy, done, abort, overflow, spurious, grant_cnt
    );

    modport slave (
        output start, gnt,
        input  req, busy, done, abort, overflow, spurious, grant_cnt
    );
endinterface

// File: rtl/req_initiator_wait_timer.sv
// WAIT cycle counter: holds the current WAIT cycle number (1-based), 0 outside WAIT.
module req_wait_timer
    import req_init_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [WCNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + WCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = (cnt_q == WCNT_W'(TIMEOUT));
endmodule

// File: rtl/req_initiator.sv
// Request initiator: queues up to 3 jobs, issues one-cycle req pulses and
// retries on grant timeout before aborting a job.
module req_initiator
    import req_init_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic clk,
    input  logic rst_n,
    req_initiator_if.master ri
);
    state_e             state_q, state_d;
    logic [PEND_W-1:0]  pending_q, pending_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [GCNT_W-1:0]  grant_cnt_q, grant_cnt_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic               overflow_q, overflow_d;
    logic               spurious_q, spurious_d;

    logic in_wait, expired, timer_en;
    logic grant_ev, timeout_ev, abort_ev, retry_ev, complete, overflow_ev;

    assign in_wait     = (state_q == ST_WAIT);
    assign grant_ev    = in_wait & ri.gnt;
    assign timeout_ev  = in_wait & ~ri.gnt & expired;
    assign abort_ev    = timeout_ev & (retry_q >= RETRY_W'(MAX_RETRY));
    assign retry_ev    = timeout_ev & ~abort_ev;
    assign complete    = grant_ev | abort_ev;
    assign overflow_ev = ri.start & ~complete & (pending_q == '1);

    // A start coinciding with a completion nets to zero change.
    always_comb begin
        pending_d = pending_q;
        if (ri.start && !complete && pending_q != '1)
            pending_d = pending_q + PEND_W'(1);
        else if (complete && !ri.start)
            pending_d = pending_q - PEND_W'(1);
    end

    always_comb begin
        retry_d = retry_q;
        if (complete)
            retry_d = '0;
        else if (retry_ev)
            retry_d = retry_q + RETRY_W'(1);
    end

    assign grant_cnt_d = grant_cnt_q + (grant_ev ? GCNT_W'(1) : GCNT_W'(0));

    always_comb begin : next_state_c
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pending_d != '0) state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (grant_ev || timeout_ev) state_d = ST_GAP;
            ST_GAP:  state_d = (pending_d != '0) ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : output_c
        req_d      = (state_d == ST_REQ);
        done_d     = grant_ev;
        abort_d    = abort_ev;
        overflow_d = overflow_ev;
        spurious_d = ri.gnt & ~in_wait;
    end

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            retry_q     <= '0;
            grant_cnt_q <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            overflow_q  <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            retry_q     <= retry_d;
            grant_cnt_q <= grant_cnt_d;
            req_q       <= req_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            overflow_q  <= overflow_d;
            spurious_q  <= spurious_d;
        end
    end

    assign timer_en = (state_d == ST_WAIT);

    req_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (~timer_en),
        .en_i      (timer_en),
        .expired_o (expired)
    );

    assign ri.req       = req_q;
    assign ri.busy      = (state_q != ST_IDLE) || (pending_q != '0);
    assign ri.done      = done_q;
    assign ri.abort     = abort_q;
    assign ri.overflow  = overflow_q;
    assign ri.spurious  = spurious_q;
    assign ri.grant_cnt = grant_cnt_q;
endmodule

// File: tb/tb_req_initiator.sv
// Directed bench for req_initiator with default TIMEOUT=4, MAX_RETRY=2.
module tb_req_initiator;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    req_initiator_if ri();

    req_initiator #(
        .TIMEOUT   (4),
        .MAX_RETRY (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ri    (ri)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job granted in its first WAIT cycle; returns done pulses seen.
    task automatic job(output int nd);
        nd = 0;
        ri.start = 1'b1; tick(); ri.start = 1'b0;
        tick();
        ri.gnt = 1'b1; tick(); ri.gnt = 1'b0;
        nd += int'(ri.done);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, nab, ndone, nsp, nov, last_req, gap_bad, ab_at, nd;
        logic r;
        n_chk = 0;
        n_err = 0;

        // reset with start/gnt active: both must be ignored
        rst_n = 1'b0; ri.start = 1'b1; ri.gnt = 1'b1;
        tick(); tick();
        chk("rst_req",      32'(ri.req), 0);
        chk("rst_busy",     32'(ri.busy), 0);
        chk("rst_pulses",   32'({ri.done, ri.abort, ri.overflow, ri.spurious}), 0);
        chk("rst_gcnt",     32'(ri.grant_cnt), 0);
        chk("rst_pending",  32'(dut.pending_q), 0);
        ri.start = 1'b0; ri.gnt = 1'b0; rst_n = 1'b1;
        tick();

        // basic grant two cycles after req
        ri.start = 1'b1; tick(); ri.start = 1'b0;
        chk("basic_req_c2",  32'(ri.req), 1);
        chk("basic_busy_c2", 32'(ri.busy), 1);
        tick();
        chk("basic_req_c3",  32'(ri.req), 0);
        tick();
        ri.gnt = 1'b1; tick(); ri.gnt = 1'b0;
        chk("basic_done_c5", 32'(ri.done), 1);
        chk("basic_gcnt",    32'(ri.grant_cnt), 1);
        tick();
        chk("basic_done_c6", 32'(ri.done), 0);
        tick();
        chk("basic_busy_c7", 32'(ri.busy), 0);

        // never granted: 3 attempts then abort
        ri.start = 1'b1; tick(); ri.start = 1'b0;
        nreq = 0; nab = 0; ndone = 0; last_req = -1; gap_bad = 0; ab_at = -1;
        for (int i = 0; i < 30; i++) begin
            if (ri.req) begin
                if (last_req >= 0 && i - last_req != 6) gap_bad++;
                last_req = i;
                nreq++;
            end
            if (ri.abort) begin nab++; ab_at = i; end
            ndone += int'(ri.done);
            tick();
        end
        chk("to_req_pulses", 32'(nreq), 3);
        chk("to_req_spacing", 32'(gap_bad), 0);
        chk("to_abort_cnt",  32'(nab), 1);
        chk("to_abort_at",   32'(ab_at), 17);
        chk("to_done_cnt",   32'(ndone), 0);
        chk("to_gcnt",       32'(ri.grant_cnt), 1);
        chk("to_busy_end",   32'(ri.busy), 0);

        // four back-to-back starts: 4th overflows
        ri.start = 1'b1; nov = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nov += int'(ri.overflow);
        end
        ri.start = 1'b0;
        chk("ov_pulse_4th",  32'(ri.overflow), 1);
        chk("ov_pulse_cnt",  32'(nov), 1);
        chk("ov_pending",    32'(dut.pending_q), 3);
        ndone = 0; nsp = 0; nab = 0;
        for (int i = 0; i < 80; i++) begin
            r = ri.req;
            tick();
            ri.gnt = r;
            ndone += int'(ri.done);
            nsp   += int'(ri.spurious);
            nab   += int'(ri.abort);
        end
        ri.gnt = 1'b0;
        chk("ov_done_cnt",   32'(ndone), 3);
        chk("ov_spurious",   32'(nsp), 0);
        chk("ov_abort",      32'(nab), 0);
        chk("ov_gcnt",       32'(ri.grant_cnt), 4);
        chk("ov_busy_end",   32'(ri.busy), 0);

        // gnt while idle
        tick();
        ri.gnt = 1'b1; tick(); ri.gnt = 1'b0;
        chk("sp_pulse",      32'(ri.spurious), 1);
        chk("sp_req",        32'(ri.req), 0);
        chk("sp_gcnt",       32'(ri.grant_cnt), 4);
        chk("sp_pending",    32'(dut.pending_q), 0);
        chk("sp_done",       32'(ri.done), 0);
        tick();
        chk("sp_pulse_end",  32'(ri.spurious), 0);

        // reset during WAIT with two jobs queued
        ri.start = 1'b1; tick(); tick(); ri.start = 1'b0;
        chk("mr_pending",    32'(dut.pending_q), 2);
        rst_n = 1'b0; ri.gnt = 1'b1; ri.start = 1'b1;
        tick();
        chk("mr_outs",       32'({ri.req, ri.busy, ri.done, ri.abort, ri.overflow, ri.spurious}), 0);
        chk("mr_gcnt",       32'(ri.grant_cnt), 0);
        rst_n = 1'b1; ri.gnt = 1'b0; ri.start = 1'b0;
        tick();
        chk("mr_post",       32'({ri.req, ri.busy, ri.done, ri.abort}), 0);
        ri.start = 1'b1; tick(); ri.start = 1'b0;
        chk("mr_restart_req", 32'(ri.req), 1);
        tick();
        ri.gnt = 1'b1; tick(); ri.gnt = 1'b0;
        chk("mr_restart_done", 32'(ri.done), 1);
        chk("mr_restart_gcnt", 32'(ri.grant_cnt), 1);
        tick(); tick();

        // grant counter wrap
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        ndone = 0;
        for (int i = 0; i < 255; i++) begin
            job(nd);
            ndone += nd;
        end
        chk("wrap_done_255", 32'(ndone), 255);
        chk("wrap_gcnt_255", 32'(ri.grant_cnt), 255);
        ri.start = 1'b1; tick(); ri.start = 1'b0;
        tick();
        ri.gnt = 1'b1; tick(); ri.gnt = 1'b0;
        chk("wrap_done",     32'(ri.done), 1);
        chk("wrap_gcnt_0",   32'(ri.grant_cnt), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
